// File: rtl/tcp_arb_pkg.sv
// tcp_arb_pkg: state encoding, default EOP position and debug bus layout for tcp_tx_arb
package tcp_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} arb_state_t;
  localparam int EOP_BIT_DEF = 0;
  localparam int DBG_CNT_LSB = 16;
  localparam int DBG_ST_LSB = 6;
  localparam int DBG_GNT_LSB = 0;
endpackage

// File: rtl/tcp_rr_pick.sv
// tcp_rr_pick: circular priority pick of the first request strictly after last
module tcp_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_SRC-1:0] gnt,
  output logic               vld
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = IW'((int'(last) + k) % NUM_SRC);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tcp_tx_arb.sv
// tcp_tx_arb: packet-granular round-robin arbiter onto one registered tx packet stream
module tcp_tx_arb
  import tcp_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DAT_WID = 256,
  parameter int MSG_WID = 20,
  parameter int EOP_BIT = EOP_BIT_DEF,
  parameter int CNT_WID = 16,
  parameter int DBG_WID = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_pkt_vld,
  output logic [NUM_SRC-1:0]         src_pkt_rdy,
  input  logic [NUM_SRC*DAT_WID-1:0] src_pkt_dat,
  input  logic [NUM_SRC*MSG_WID-1:0] src_pkt_msg,
  output logic                       tx_pkt_vld,
  input  logic                       tx_pkt_rdy,
  output logic [DAT_WID-1:0]         tx_pkt_dat,
  output logic [MSG_WID-1:0]         tx_pkt_msg,
  input  logic [NUM_SRC-1:0]         cfg_src_en,
  output logic [NUM_SRC-1:0]         cur_grant,
  output logic [CNT_WID-1:0]         pkt_cnt,
  output logic [DBG_WID-1:0]         dbg_sig
);
  localparam int IW = $clog2(NUM_SRC);
  arb_state_t state, state_nx;
  logic [NUM_SRC-1:0] req, pick;
  logic pick_vld, slot_free, sel_vld, acc, eop;
  logic [IW-1:0] last_grant, gidx;
  logic [DAT_WID-1:0] sel_dat;
  logic [MSG_WID-1:0] sel_msg;
  logic [31:0] dbg;
  assign req = src_pkt_vld & cfg_src_en;
  tcp_rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .req(req),
    .last(last_grant),
    .gnt(pick),
    .vld(pick_vld)
  );
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    sel_msg = '0;
    gidx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_grant[i]) begin
        sel_vld = src_pkt_vld[i];
        sel_dat = src_pkt_dat[i*DAT_WID +: DAT_WID];
        sel_msg = src_pkt_msg[i*MSG_WID +: MSG_WID];
        gidx = IW'(i);
      end
    end
  end
  always_comb begin
    slot_free = !tx_pkt_vld || tx_pkt_rdy;
    src_pkt_rdy = (state == BUSY && slot_free) ? cur_grant : '0;
    acc = state == BUSY && slot_free && sel_vld;
    eop = acc && sel_msg[EOP_BIT];
    state_nx = state == IDLE ? (pick_vld ? BUSY : IDLE) : (eop ? IDLE : BUSY);
  end
  always_comb begin
    dbg = '0;
    dbg[DBG_CNT_LSB +: 16] = 16'(pkt_cnt);
    dbg[DBG_ST_LSB +: 2] = state;
    dbg[DBG_GNT_LSB +: 4] = 4'(cur_grant);
  end
  assign dbg_sig = DBG_WID'(dbg);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_grant <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      pkt_cnt <= '0;
      tx_pkt_vld <= 1'b0;
      tx_pkt_dat <= '0;
      tx_pkt_msg <= '0;
    end else begin
      if (state == IDLE && pick_vld) cur_grant <= pick;
      else if (eop) begin
        cur_grant <= '0;
        last_grant <= gidx;
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (acc) begin
        tx_pkt_vld <= 1'b1;
        tx_pkt_dat <= sel_dat;
        tx_pkt_msg <= sel_msg;
      end else if (slot_free) tx_pkt_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tcp_tx_arb.sv
// tb_tcp_tx_arb: randomized packet traffic checked against a packet-level round-robin model
module tb_tcp_tx_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] src_pkt_vld, src_pkt_rdy, cfg_src_en, cur_grant;
  logic [1023:0] src_pkt_dat;
  logic [79:0] src_pkt_msg;
  logic tx_pkt_vld, tx_pkt_rdy;
  logic [255:0] tx_pkt_dat;
  logic [19:0] tx_pkt_msg;
  logic [15:0] pkt_cnt;
  logic [31:0] dbg_sig;
  int total = 0;
  int bad = 0;
  int glog[$];
  int tlog[$];

  tcp_tx_arb dut (
    .clk(clk), .rst_n(rst_n),
    .src_pkt_vld(src_pkt_vld), .src_pkt_rdy(src_pkt_rdy),
    .src_pkt_dat(src_pkt_dat), .src_pkt_msg(src_pkt_msg),
    .tx_pkt_vld(tx_pkt_vld), .tx_pkt_rdy(tx_pkt_rdy),
    .tx_pkt_dat(tx_pkt_dat), .tx_pkt_msg(tx_pkt_msg),
    .cfg_src_en(cfg_src_en), .cur_grant(cur_grant),
    .pkt_cnt(pkt_cnt), .dbg_sig(dbg_sig)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mk_dat(int i, int s, int b, int salt);
    return {8'(i), 16'(s), 8'(b), {7{32'(salt ^ (i * 977) ^ (s * 131) ^ b)}}};
  endfunction

  function automatic logic [19:0] mk_msg(int i, int s, int b, int len);
    return {4'(i), 8'(s), 7'(b), b == len - 1};
  endfunction

  // next source by the round-robin rule: first enabled requester strictly after last, circularly
  function automatic int rr_next(int last, logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic drive_beat(input int i, input logic v, input logic [255:0] d, input logic [19:0] m);
    src_pkt_vld[i] = v;
    src_pkt_dat[i*256 +: 256] = d;
    src_pkt_msg[i*20 +: 20] = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_pkt_vld = '0;
    src_pkt_dat = '0;
    src_pkt_msg = '0;
    tx_pkt_rdy = 1'b1;
    cfg_src_en = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_traffic(input int npk, input logic [3:0] en, input logic [3:0] act,
                             input int flen, input int rdy_pct, input int gap_pct, output int cyc_done);
    int len_tab[4][64];
    int seq[4], b[4], eseq[4];
    int exp_src, exp_b, exp_last, done, cyc, salt;
    logic pv, pr;
    logic [255:0] pd;
    logic [19:0] pm;
    salt = int'($urandom);
    cfg_src_en = en;
    glog.delete();
    tlog.delete();
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; b[i] = 0; eseq[i] = 0;
      for (int s = 0; s < 64; s++) len_tab[i][s] = flen > 0 ? flen : int'($urandom_range(1, 4));
    end
    exp_src = -1; exp_b = 0; exp_last = 3; done = 0; cyc = 0; cyc_done = -1;
    pv = 1'b0; pr = 1'b0; pd = '0; pm = '0;
    while (done < npk && cyc < 4000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        drive_beat(i, act[i] && (b[i] == 0 || $urandom_range(99) >= gap_pct),
                   mk_dat(i, seq[i], b[i], salt), mk_msg(i, seq[i], b[i], len_tab[i][seq[i]]));
      tx_pkt_rdy = $urandom_range(99) < rdy_pct;
      #1;
      cyc++;
      total++;
      if ((src_pkt_rdy & ~cur_grant) != 0 || $countones(cur_grant) > 1) begin
        bad++;
        $display("FAIL rdy_vs_grant: rdy=%b grant=%b, want one-hot grant covering rdy", src_pkt_rdy, cur_grant);
      end
      if (pv && !pr) begin
        total++;
        if (tx_pkt_vld !== 1'b1 || tx_pkt_dat !== pd || tx_pkt_msg !== pm) begin
          bad++;
          $display("FAIL hold: vld=%b msg=%h, want vld=1 msg=%h held", tx_pkt_vld, tx_pkt_msg, pm);
        end
      end
      if (tx_pkt_vld && tx_pkt_rdy) begin
        if (exp_src < 0) begin
          exp_src = rr_next(exp_last, en & act);
          exp_b = 0;
        end
        total++;
        if (tx_pkt_dat !== mk_dat(exp_src, eseq[exp_src], exp_b, salt) ||
            tx_pkt_msg !== mk_msg(exp_src, eseq[exp_src], exp_b, len_tab[exp_src][eseq[exp_src]])) begin
          bad++;
          $display("FAIL beat: msg=%h, want msg=%h (src %0d)", tx_pkt_msg,
                   mk_msg(exp_src, eseq[exp_src], exp_b, len_tab[exp_src][eseq[exp_src]]), exp_src);
        end
        if (exp_b == len_tab[exp_src][eseq[exp_src]] - 1) begin
          glog.push_back(int'(tx_pkt_msg[19:16]));
          tlog.push_back(cyc);
          exp_last = exp_src;
          eseq[exp_src]++;
          exp_src = -1;
          done++;
        end else exp_b++;
      end
      if (cyc_done < 0 && pkt_cnt == 16'(npk)) cyc_done = cyc - 1;
      for (int i = 0; i < 4; i++)
        if (src_pkt_vld[i] && src_pkt_rdy[i]) begin
          b[i]++;
          if (b[i] == len_tab[i][seq[i]]) begin
            b[i] = 0;
            seq[i]++;
          end
        end
      pv = tx_pkt_vld; pr = tx_pkt_rdy; pd = tx_pkt_dat; pm = tx_pkt_msg;
    end
    total++;
    if (done < npk) begin
      bad++;
      $display("FAIL timeout: packets=%0d, want %0d", done, npk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (tx_pkt_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", tx_pkt_vld); end
    total++; if (cur_grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b want 0000", cur_grant); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", pkt_cnt); end
    total++; if (src_pkt_rdy !== 4'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0000", src_pkt_rdy); end
    total++; if (tx_pkt_dat !== 256'd0 || tx_pkt_msg !== 20'd0) begin bad++; $display("FAIL reset_data: msg %h want 0", tx_pkt_msg); end
    total++; if (dbg_sig !== 32'd0) begin bad++; $display("FAIL reset_dbg: got %h want 0", dbg_sig); end
    @(negedge clk);
    total++; if (cur_grant !== 4'b0) begin bad++; $display("FAIL idle_grant: got %b want 0000", cur_grant); end
  endtask

  task automatic test_single();
    logic [255:0] d[3];
    logic [19:0] m[3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      d[k] = rnd256();
      m[k] = {19'($urandom), k == 2};
    end
    drive_beat(1, 1'b1, d[0], m[0]);
    @(negedge clk);
    total++; if (cur_grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", cur_grant); end
    total++; if (src_pkt_rdy !== 4'b0010) begin bad++; $display("FAIL single_rdy: got %b want 0010", src_pkt_rdy); end
    total++; if (tx_pkt_vld !== 1'b0) begin bad++; $display("FAIL single_bubble: got %b want 0", tx_pkt_vld); end
    total++; if (dbg_sig !== 32'h0000_0042) begin bad++; $display("FAIL single_dbg_busy: got %h want 00000042", dbg_sig); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (tx_pkt_vld !== 1'b1 || tx_pkt_dat !== d[k] || tx_pkt_msg !== m[k]) begin
        bad++;
        $display("FAIL single_beat%0d: vld=%b msg=%h want vld=1 msg=%h", k, tx_pkt_vld, tx_pkt_msg, m[k]);
      end
      if (k < 2) drive_beat(1, 1'b1, d[k+1], m[k+1]);
      else drive_beat(1, 1'b0, '0, '0);
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", pkt_cnt); end
    total++; if (cur_grant !== 4'b0) begin bad++; $display("FAIL single_release: got %b want 0000", cur_grant); end
    total++; if (dbg_sig !== 32'h0001_0000) begin bad++; $display("FAIL single_dbg_idle: got %h want 00010000", dbg_sig); end
    @(negedge clk);
    total++; if (tx_pkt_vld !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", tx_pkt_vld); end
  endtask

  task automatic test_rr();
    int cd;
    do_reset();
    run_traffic(8, 4'hF, 4'hF, 2, 100, 0, cd);
    total++; if (cd !== 24) begin bad++; $display("FAIL rr_rate: 8 packets took %0d cycles want 24", cd); end
    total++; if (pkt_cnt !== 16'd8) begin bad++; $display("FAIL rr_cnt: got %0d want 8", pkt_cnt); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= glog.size() || glog[k] != k % 4) begin
        bad++;
        $display("FAIL rr_order%0d: got %0d want %0d", k, k < glog.size() ? glog[k] : -1, k % 4);
      end
    end
  endtask

  task automatic test_stall();
    logic [255:0] d[4];
    logic [19:0] m[4];
    logic [255:0] got[$];
    int bi = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d[k] = rnd256();
      m[k] = {19'($urandom), k == 3};
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      drive_beat(2, bi < 4, d[bi % 4], m[bi % 4]);
      tx_pkt_rdy = !(c >= 4 && c < 9);
      #1;
      if (c >= 4 && c < 9) begin
        total++;
        if (tx_pkt_vld !== 1'b1 || tx_pkt_dat !== d[2] || tx_pkt_msg !== m[2] || src_pkt_rdy !== 4'b0) begin
          bad++;
          $display("FAIL stall_c%0d: vld=%b msg=%h rdy=%b want vld=1 msg=%h rdy=0000", c, tx_pkt_vld, tx_pkt_msg, src_pkt_rdy, m[2]);
        end
      end
      if (tx_pkt_vld && tx_pkt_rdy) got.push_back(tx_pkt_dat);
      if (src_pkt_vld[2] && src_pkt_rdy[2]) bi++;
    end
    total++; if (got.size() != 4) begin bad++; $display("FAIL stall_count: got %0d beats want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++; if (got[k] !== d[k]) begin bad++; $display("FAIL stall_data%0d: got %h want %h", k, got[k][31:0], d[k][31:0]); end
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_en();
    int cd;
    do_reset();
    run_traffic(30, 4'b1011, 4'hF, 0, 70, 25, cd);
    total++; if (glog.size() != 30) begin bad++; $display("FAIL en_count: got %0d want 30", glog.size()); end
    foreach (glog[k]) begin
      total++; if (glog[k] == 2) begin bad++; $display("FAIL en_masked: packet %0d from source 2 want never", k); end
    end
  endtask

  task automatic test_en_mid();
    int b[2], seq[2];
    int gl[$];
    logic [3:0] prev_g = '0;
    do_reset();
    b = '{0, 0};
    seq = '{0, 0};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 2) cfg_src_en = 4'b1110;
      for (int i = 0; i < 2; i++) drive_beat(i, 1'b1, mk_dat(i, seq[i], b[i], 7), mk_msg(i, seq[i], b[i], 3));
      #1;
      if (cur_grant != 4'b0 && prev_g == 4'b0) gl.push_back(int'(cur_grant));
      prev_g = cur_grant;
      for (int i = 0; i < 2; i++)
        if (src_pkt_vld[i] && src_pkt_rdy[i]) begin
          b[i]++;
          if (b[i] == 3) begin
            b[i] = 0;
            seq[i]++;
          end
        end
    end
    total++; if (gl.size() != 8) begin bad++; $display("FAIL enmid_grants: got %0d want 8", gl.size()); end
    total++; if (gl.size() == 0 || gl[0] != 1) begin bad++; $display("FAIL enmid_first: got %0d want 1", gl.size() ? gl[0] : -1); end
    for (int k = 1; k < gl.size(); k++) begin
      total++; if (gl[k] != 2) begin bad++; $display("FAIL enmid_skip%0d: grant %b want 0010", k, 4'(gl[k])); end
    end
    total++; if (seq[0] != 1) begin bad++; $display("FAIL enmid_finish: source 0 packets %0d want 1", seq[0]); end
    total++; if (pkt_cnt !== 16'd7) begin bad++; $display("FAIL enmid_cnt: got %0d want 7", pkt_cnt); end
  endtask

  task automatic test_b2b();
    int cd;
    do_reset();
    run_traffic(6, 4'hF, 4'b1000, 1, 100, 0, cd);
    total++; if (cd !== 12) begin bad++; $display("FAIL b2b_rate: 6 packets took %0d cycles want 12", cd); end
    for (int k = 1; k < 6 && k < tlog.size(); k++) begin
      total++; if (tlog[k] - tlog[k-1] != 2) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 2", k, tlog[k] - tlog[k-1]); end
    end
  endtask

  task automatic test_reset_mid();
    int b = 0;
    int seq = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_beat(0, 1'b1, mk_dat(0, seq, b, 3), mk_msg(0, seq, b, 3));
      #1;
      if (src_pkt_vld[0] && src_pkt_rdy[0]) begin
        b++;
        if (b == 3) begin
          b = 0;
          seq++;
        end
      end
    end
    @(posedge clk);
    #2;
    total++;
    if (pkt_cnt !== 16'd1 || tx_pkt_vld !== 1'b1 || cur_grant !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_pre: cnt=%0d vld=%b grant=%b want 1,1,0001", pkt_cnt, tx_pkt_vld, cur_grant);
    end
    rst_n = 1'b0;
    #1;
    total++; if (tx_pkt_vld !== 1'b0) begin bad++; $display("FAIL rstmid_vld: got %b want 0", tx_pkt_vld); end
    total++; if (cur_grant !== 4'b0) begin bad++; $display("FAIL rstmid_grant: got %b want 0000", cur_grant); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", pkt_cnt); end
    total++; if (src_pkt_rdy !== 4'b0 || tx_pkt_dat !== 256'd0) begin bad++; $display("FAIL rstmid_clear: rdy=%b want 0000 and data 0", src_pkt_rdy); end
    drive_beat(0, 1'b1, mk_dat(0, 9, 0, 3), mk_msg(0, 9, 0, 1));
    drive_beat(1, 1'b1, mk_dat(1, 9, 0, 3), mk_msg(1, 9, 0, 1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cur_grant !== 4'b0001) begin bad++; $display("FAIL rstmid_first: got %b want 0001", cur_grant); end
  endtask

  task automatic test_random();
    int cd;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_traffic(20, 4'($urandom_range(1, 15)), 4'hF, 0, int'($urandom_range(40, 100)), int'($urandom_range(0, 40)), cd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_pkt_rdy = 1'b1;
    cfg_src_en = 4'hF;
    src_pkt_vld = '0;
    src_pkt_dat = '0;
    src_pkt_msg = '0;
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_en();
    test_en_mid();
    test_b2b();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tcp_tx_arb.md
Name: tcp_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares one TOE tx packet stream (vld/rdy + DAT_WID data + MSG_WID sideband) among NUM_SRC packet sources, e.g. the poll generator, the ACK engine and the retransmit engine.
- A grant is held from the first beat of a packet until the beat carrying the end-of-packet flag, so packets never interleave.
- Output is fully registered and feeds the MAC-side tx path.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- DAT_WID, 256, data beat width
- MSG_WID, 20, sideband message width
- EOP_BIT, 0, index in msg of the end-of-packet flag
- CNT_WID, 16, width of the per-arbiter packet counter
- DBG_WID, 32, debug bus width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- src_pkt_vld  in  NUM_SRC  per-source beat valid
- src_pkt_rdy  out  NUM_SRC  per-source beat ready
- src_pkt_dat  in  NUM_SRC*DAT_WID  per-source data, source i at [i*DAT_WID +: DAT_WID]
- src_pkt_msg  in  NUM_SRC*MSG_WID  per-source sideband, source i at [i*MSG_WID +: MSG_WID]
- tx_pkt_vld  out  1  output beat valid (registered)
- tx_pkt_rdy  in  1  downstream ready
- tx_pkt_dat  out  DAT_WID  output data (registered)
- tx_pkt_msg  out  MSG_WID  output sideband (registered)
- cfg_src_en  in  NUM_SRC  per-source arbitration enable
- cur_grant  out  NUM_SRC  one-hot current grant, 0 when idle
- pkt_cnt  out  CNT_WID  count of completed packets, wraps
- dbg_sig  out  DBG_WID  {pkt_cnt[15:0], 8'h0, state[1:0], 2'b0, cur_grant[3:0]}, zero-padded/truncated for other NUM_SRC

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cur_grant=0, last_grant=NUM_SRC-1 so source 0 wins first, tx_pkt_vld=0, tx_pkt_dat=0, tx_pkt_msg=0, pkt_cnt=0, all src_pkt_rdy=0.
- Any reset mid-packet drops the partial packet; the output register is cleared, with no flush.
- Request vector: req = src_pkt_vld & cfg_src_en.
- States: IDLE, BUSY.
- IDLE:
  - src_pkt_rdy = 0.
  - If req != 0, pick the first set bit strictly after last_grant, searching circularly.
  - Register it into cur_grant and move to BUSY.
  - Arbitration costs one bubble cycle per packet.
- BUSY, grant g:
  - slot_free = !tx_pkt_vld || tx_pkt_rdy.
  - src_pkt_rdy[g] = slot_free; all other src_pkt_rdy bits = 0.
  - Accept = src_pkt_vld[g] && src_pkt_rdy[g]. On accept, the output register loads dat/msg of g and tx_pkt_vld=1.
  - If slot_free and no accept: tx_pkt_vld=0. Otherwise the output register holds and is stable while tx_pkt_vld && !tx_pkt_rdy.
  - Accept with msg[EOP_BIT]=1: next state IDLE, last_grant=g, cur_grant=0, pkt_cnt+1 (wraps at 2^CNT_WID).
- Sustained rate: 1 beat/cycle within a packet; a new grant is issued the cycle after EOP acceptance.
- Single-beat packets (EOP on the first beat) are legal and take 2 cycles each.
- Deasserting cfg_src_en[g] during BUSY does not abort; the packet completes and the change affects the next arbitration only.
- src_pkt_vld[g] low mid-packet: the grant is held indefinitely, with no timeout.
- Latency: source beat to tx_pkt_vld is 1 cycle.
- Data/msg of the output register change only on accept.

Decomposition:
- Package tcp_arb_pkg holds the IDLE/BUSY state encoding, the default EOP_BIT and the dbg_sig field offsets.
- Sub-module tcp_rr_pick: combinational circular priority pick. Inputs are req[NUM_SRC] and last_grant index; outputs are one-hot grant and a valid flag.
- tcp_tx_arb owns the FSM, ready generation, output register and counter.

Test Plan:
- Single source 1, 3-beat packet (EOP on beat 3), tx_pkt_rdy=1 -> cur_grant=4'b0010 one cycle after vld, tx beats appear on cycles 2..4 with identical dat/msg, pkt_cnt=1.
- All 4 sources continuously posting 2-beat packets -> grant order 0,1,2,3,0; no interleaving; pkt_cnt=8 after 8 packets; 3 cycles per packet.
- tx_pkt_rdy held 0 for 5 cycles mid-packet -> tx_pkt_dat/msg frozen, src_pkt_rdy[g]=0, no beat lost or duplicated.
- cfg_src_en=4'b1011, all requesting -> source 2 never granted; clearing cfg_src_en[0] mid-packet of source 0 lets that packet finish, then source 0 is skipped.
- Back-to-back single-beat packets from source 3 only -> one output beat every 2 cycles, pkt_cnt increments each.
- rst_n pulsed low mid-packet -> tx_pkt_vld=0, cur_grant=0, pkt_cnt=0 immediately; first grant after release goes to source 0 if it requests.
